// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI3 response/burst encodings and state types for axi_ram_slave.
package axi_pkg;
   localparam logic [1:0] OKAY    = 2'b00;
   localparam logic [1:0] SLVERR  = 2'b10;
   localparam logic [1:0] DECERR  = 2'b11;
   localparam logic [1:0] FIXED   = 2'b00;
   localparam logic [1:0] INCR    = 2'b01;
   localparam logic [1:0] WRAP    = 2'b10;
   localparam logic [2:0] SIZE_8B = 3'd3;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_BURST} r_state_e;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
      return !(burst == FIXED || burst == INCR) || size != SIZE_8B;
   endfunction
endpackage

// File: rtl/axi_ram_dp.sv
// axi_ram_dp: simple dual-port 64-bit RAM, byte-enabled write, registered read-first read.
module axi_ram_dp #(
   parameter int DEPTH = 4096
) (
   input  logic                     clk_i,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [63:0]              i_wdata,
   input  logic [7:0]               i_wstrb,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [63:0]              o_rdata
);
   logic [63:0] r_mem [DEPTH];

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 8; b++)
         if (i_we && i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      if (i_re) o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI3 64-bit responder backing a BASE-mapped window with on-chip RAM.
// Define AXI_RAM_STALL_EN to throttle the readies and read issue with a 16-bit LFSR.
module axi_ram_slave
   import axi_pkg::*;
#(
   parameter logic [31:0] BASE  = 32'h2000_0000,
   parameter int          DEPTH = 4096
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_awaddr,
   input  logic [3:0]  s_axi_awlen,
   input  logic [2:0]  s_axi_awsize,
   input  logic [1:0]  s_axi_awburst,
   input  logic [5:0]  s_axi_awid,
   input  logic [1:0]  s_axi_awlock,
   input  logic [3:0]  s_axi_awcache,
   input  logic [2:0]  s_axi_awprot,
   input  logic [3:0]  s_axi_awqos,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   input  logic [63:0] s_axi_wdata,
   input  logic [7:0]  s_axi_wstrb,
   input  logic        s_axi_wlast,
   input  logic [5:0]  s_axi_wid,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   output logic [1:0]  s_axi_bresp,
   output logic [5:0]  s_axi_bid,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   input  logic [31:0] s_axi_araddr,
   input  logic [3:0]  s_axi_arlen,
   input  logic [2:0]  s_axi_arsize,
   input  logic [1:0]  s_axi_arburst,
   input  logic [5:0]  s_axi_arid,
   input  logic [1:0]  s_axi_arlock,
   input  logic [3:0]  s_axi_arcache,
   input  logic [2:0]  s_axi_arprot,
   input  logic [3:0]  s_axi_arqos,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [63:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rlast,
   output logic [5:0]  s_axi_rid
);
   localparam int          AW  = $clog2(DEPTH);
   localparam logic [31:0] WIN = 32'(DEPTH * 8);

   w_state_e    r_wstate, w_wnext;
   r_state_e    r_rstate, w_rnext;
   logic        r_up, w_go, w_rgo;
   logic [31:0] r_waddr, r_raddr, w_woff, w_roff;
   logic [3:0]  r_wlen, r_wcnt, r_rlen, r_rcnt;
   logic [5:0]  r_wid, r_rid;
   logic        r_wincr, r_wbad, r_werr, r_wdec;
   logic        r_rincr, r_rbad, r_rdone, r_pend, r_pend_last;
   logic [1:0]  r_pend_resp, r_sk_cnt;
   beat_t [1:0] r_sk;
   beat_t       w_beat;
   logic [63:0] w_ram_q;
   logic        w_aw_hs, w_w_hs, w_ar_hs, w_pop, w_issue, w_win, w_rin, w_we, w_re, w_slot;
   logic        w_unused;

   assign w_unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_wid,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

`ifdef AXI_RAM_STALL_EN
   logic [15:0] r_lfsr;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) r_lfsr <= 16'hACE1;
      else r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   assign w_go  = |r_lfsr[1:0];
   assign w_rgo = |r_lfsr[3:2];
`else
   assign w_go  = 1'b1;
   assign w_rgo = 1'b1;
`endif

   // Readies stay low until the first edge after reset release.
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) r_up <= 1'b0;
      else r_up <= 1'b1;

   assign w_woff        = r_waddr - BASE;
   assign w_win         = w_woff < WIN;
   assign s_axi_awready = r_up && w_go && r_wstate == W_IDLE;
   assign s_axi_wready  = w_go && r_wstate == W_DATA;
   assign s_axi_bvalid  = r_wstate == W_RESP;
   assign s_axi_bid     = r_wid;
   assign s_axi_bresp   = (r_wbad || r_werr) ? SLVERR : r_wdec ? DECERR : OKAY;
   assign w_aw_hs       = s_axi_awvalid && s_axi_awready;
   assign w_w_hs        = s_axi_wvalid && s_axi_wready;
   assign w_we          = w_w_hs && !r_wbad && w_win;

   always_comb begin
      w_wnext = r_wstate;
      if (w_aw_hs) w_wnext = W_DATA;
      if (w_w_hs && s_axi_wlast) w_wnext = W_RESP;
      if (s_axi_bvalid && s_axi_bready) w_wnext = W_IDLE;
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_wstate <= W_IDLE;
         r_waddr  <= '0;
         r_wlen   <= '0;
         r_wcnt   <= '0;
         r_wid    <= '0;
         r_wincr  <= 1'b0;
         r_wbad   <= 1'b0;
         r_werr   <= 1'b0;
         r_wdec   <= 1'b0;
      end else begin
         r_wstate <= w_wnext;
         if (w_aw_hs) begin
            r_waddr <= s_axi_awaddr;
            r_wlen  <= s_axi_awlen;
            r_wcnt  <= '0;
            r_wid   <= s_axi_awid;
            r_wincr <= s_axi_awburst == INCR;
            r_wbad  <= burst_bad(s_axi_awburst, s_axi_awsize);
            r_werr  <= 1'b0;
            r_wdec  <= 1'b0;
         end
         if (w_w_hs) begin
            r_waddr <= r_waddr + (r_wincr ? 32'd8 : 32'd0);
            r_wcnt  <= r_wcnt + 4'd1;
            if (s_axi_wlast != (r_wcnt == r_wlen)) r_werr <= 1'b1;
            if (!w_win) r_wdec <= 1'b1;
         end
      end

   assign w_roff        = r_raddr - BASE;
   assign w_rin         = w_roff < WIN;
   assign s_axi_arready = r_up && w_go && r_rstate == R_IDLE;
   assign w_ar_hs       = s_axi_arvalid && s_axi_arready;
   assign s_axi_rvalid  = r_sk_cnt != 2'd0;
   assign s_axi_rdata   = r_sk[0].data;
   assign s_axi_rresp   = r_sk[0].resp;
   assign s_axi_rlast   = r_sk[0].last;
   assign s_axi_rid     = r_rid;
   assign w_pop         = s_axi_rvalid && s_axi_rready;
   // Count the in-flight RAM read against skid space so backpressure never overflows it.
   assign w_issue = w_rgo && r_rstate == R_BURST && !r_rdone &&
                    ({1'b0, r_sk_cnt} + 3'(r_pend) - 3'(w_pop) < 3'd2);
   assign w_re    = w_issue && !r_rbad && w_rin;
   assign w_slot  = r_sk_cnt[1] | (r_sk_cnt[0] & !w_pop);
   assign w_beat  = '{data: r_pend_resp == OKAY ? w_ram_q : 64'h0, resp: r_pend_resp, last: r_pend_last};

   always_comb begin
      w_rnext = r_rstate;
      if (w_ar_hs) w_rnext = R_BURST;
      if (w_pop && s_axi_rlast) w_rnext = R_IDLE;
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_rstate    <= R_IDLE;
         r_raddr     <= '0;
         r_rlen      <= '0;
         r_rcnt      <= '0;
         r_rid       <= '0;
         r_rincr     <= 1'b0;
         r_rbad      <= 1'b0;
         r_rdone     <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_resp <= OKAY;
         r_pend_last <= 1'b0;
         r_sk        <= '0;
         r_sk_cnt    <= '0;
      end else begin
         r_rstate <= w_rnext;
         if (w_ar_hs) begin
            r_raddr <= s_axi_araddr;
            r_rlen  <= s_axi_arlen;
            r_rcnt  <= '0;
            r_rid   <= s_axi_arid;
            r_rincr <= s_axi_arburst == INCR;
            r_rbad  <= burst_bad(s_axi_arburst, s_axi_arsize);
            r_rdone <= 1'b0;
         end
         r_pend <= w_issue;
         if (w_issue) begin
            r_raddr     <= r_raddr + (r_rincr ? 32'd8 : 32'd0);
            r_rcnt      <= r_rcnt + 4'd1;
            r_rdone     <= r_rcnt == r_rlen;
            r_pend_resp <= r_rbad ? SLVERR : w_rin ? OKAY : DECERR;
            r_pend_last <= r_rcnt == r_rlen;
         end
         if (w_pop) r_sk[0] <= r_sk[1];
         if (r_pend) r_sk[w_slot] <= w_beat;
         r_sk_cnt <= r_sk_cnt + 2'(r_pend) - 2'(w_pop);
      end

   axi_ram_dp #(.DEPTH(DEPTH)) u_ram (
      .clk_i   (clk_i),
      .i_we    (w_we),
      .i_waddr (w_woff[AW+2:3]),
      .i_wdata (s_axi_wdata),
      .i_wstrb (s_axi_wstrb),
      .i_re    (w_re),
      .i_raddr (w_roff[AW+2:3]),
      .o_rdata (w_ram_q)
   );
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed write/read bursts against axi_ram_slave with hand-computed expectations.
module tb_axi_ram_slave;
   import axi_pkg::*;
   localparam logic [31:0] BASE  = 32'h2000_0000;
   localparam int          DEPTH = 4096;

   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        s_axi_awvalid = 1'b0, s_axi_awready;
   logic [31:0] s_axi_awaddr = '0;
   logic [3:0]  s_axi_awlen = '0;
   logic [2:0]  s_axi_awsize = '0;
   logic [1:0]  s_axi_awburst = '0;
   logic [5:0]  s_axi_awid = '0;
   logic        s_axi_wvalid = 1'b0, s_axi_wready;
   logic [63:0] s_axi_wdata = '0;
   logic [7:0]  s_axi_wstrb = '0;
   logic        s_axi_wlast = 1'b0;
   logic [5:0]  s_axi_wid = '0;
   logic        s_axi_bvalid, s_axi_bready = 1'b0;
   logic [1:0]  s_axi_bresp;
   logic [5:0]  s_axi_bid;
   logic        s_axi_arvalid = 1'b0, s_axi_arready;
   logic [31:0] s_axi_araddr = '0;
   logic [3:0]  s_axi_arlen = '0;
   logic [2:0]  s_axi_arsize = '0;
   logic [1:0]  s_axi_arburst = '0;
   logic [5:0]  s_axi_arid = '0;
   logic        s_axi_rvalid, s_axi_rready = 1'b0;
   logic [63:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rlast;
   logic [5:0]  s_axi_rid;

   always #5 clk_i = ~clk_i;

   axi_ram_slave #(.BASE(BASE), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
      .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
      .s_axi_awid(s_axi_awid), .s_axi_awlock(2'b00), .s_axi_awcache(4'h3), .s_axi_awprot(3'h0),
      .s_axi_awqos(4'h0),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
      .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast), .s_axi_wid(s_axi_wid),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
      .s_axi_bid(s_axi_bid),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
      .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
      .s_axi_arid(s_axi_arid), .s_axi_arlock(2'b00), .s_axi_arcache(4'h3), .s_axi_arprot(3'h0),
      .s_axi_arqos(4'h0),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
      .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rid(s_axi_rid)
   );

   int          n_vec = 0, n_err = 0;
   logic [63:0] wd [16];
   logic [63:0] rq_d [16];
   logic [1:0]  rq_r [16];
   logic [15:0] rq_lmask;
   logic [5:0]  rq_id;
   int          rq_n, rq_lat, rq_span, rq_unstable, rq_to;
   logic [1:0]  resp;
   logic [5:0]  bid;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                     input logic [2:0] size, input int nb, input logic [7:0] strb, input logic [5:0] id,
                     output logic [1:0] r, output logic [5:0] b);
      int to = 0;
      s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst; s_axi_awsize = size;
      s_axi_awid = id; s_axi_awvalid = 1'b1;
      for (int k = 0; k < 50 && !s_axi_awready; k++) @(negedge clk_i);
      if (!s_axi_awready) to++;
      @(negedge clk_i);
      s_axi_awvalid = 1'b0;
      for (int i = 0; i < nb; i++) begin
         s_axi_wvalid = 1'b1; s_axi_wdata = wd[i]; s_axi_wstrb = strb;
         s_axi_wlast = (i == nb - 1); s_axi_wid = id;
         for (int k = 0; k < 50 && !s_axi_wready; k++) @(negedge clk_i);
         if (!s_axi_wready) to++;
         @(negedge clk_i);
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      s_axi_bready = 1'b1;
      for (int k = 0; k < 50 && !s_axi_bvalid; k++) @(negedge clk_i);
      if (!s_axi_bvalid) to++;
      r = s_axi_bresp; b = s_axi_bid;
      @(negedge clk_i);
      s_axi_bready = 1'b0;
      chk("wr_timeout", 64'(to), 64'h0);
   endtask

   // mode 0: rready held high; mode 1: rready pattern 1,0,0,1. rst_at >= 0 asserts reset at that beat.
   task automatic rd(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                     input logic [2:0] size, input logic [5:0] id, input int mode, input int rst_at);
      logic        stall = 1'b0;
      logic [63:0] held = '0;
      rq_n = 0; rq_lat = -1; rq_span = 0; rq_unstable = 0; rq_to = 0; rq_lmask = '0; rq_id = '0;
      s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst; s_axi_arsize = size;
      s_axi_arid = id; s_axi_arvalid = 1'b1;
      for (int k = 0; k < 50 && !s_axi_arready; k++) @(negedge clk_i);
      if (!s_axi_arready) rq_to++;
      @(negedge clk_i);
      s_axi_arvalid = 1'b0;
      for (int k = 1; k < 400 && rq_n < int'(len) + 1; k++) begin
         s_axi_rready = (mode == 0) || (k % 4 == 1) || (k % 4 == 0);
         if (stall && (!s_axi_rvalid || s_axi_rdata !== held)) rq_unstable++;
         stall = 1'b0;
         if (s_axi_rvalid) begin
            if (rq_lat < 0) begin
               rq_lat = k - 1;
               rq_id = s_axi_rid;
            end
            if (rq_n == rst_at) begin
               s_axi_rready = 1'b0;
               rst_i = 1'b1;
               #1;
               chk("rst_rvalid_async", 64'(s_axi_rvalid), 64'h0);
               return;
            end
            if (s_axi_rready) begin
               rq_d[rq_n] = s_axi_rdata;
               rq_r[rq_n] = s_axi_rresp;
               rq_lmask[rq_n] = s_axi_rlast;
               rq_span = k - 1 - rq_lat;
               rq_n++;
            end else begin
               stall = 1'b1;
               held = s_axi_rdata;
            end
         end
         @(negedge clk_i);
      end
      s_axi_rready = 1'b0;
      if (rq_n < int'(len) + 1) rq_to++;
      chk("rd_timeout", 64'(rq_to), 64'h0);
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      chk("rst_readies", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'h0);
      chk("rst_valids", 64'({s_axi_bvalid, s_axi_rvalid}), 64'h0);
      chk("rst_resp_last", 64'({s_axi_bresp, s_axi_rresp, s_axi_rlast}), 64'h0);
      chk("rst_ids", 64'({s_axi_bid, s_axi_rid}), 64'h0);
      chk("rst_rdata", s_axi_rdata, 64'h0);
      rst_i = 1'b0;
      chk("ready_before_edge", 64'({s_axi_awready, s_axi_arready}), 64'h0);
      @(negedge clk_i);
      chk("ready_after_edge", 64'({s_axi_awready, s_axi_arready}), 64'h3);

      for (int i = 0; i < 4; i++) wd[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
      wr(BASE, 4'd3, INCR, SIZE_8B, 4, 8'hFF, 6'h05, resp, bid);
      chk("incr_bresp", 64'(resp), 64'(OKAY));
      chk("incr_bid", 64'(bid), 64'h05);
      rd(BASE, 4'd3, INCR, SIZE_8B, 6'h09, 0, -1);
      for (int i = 0; i < 4; i++) chk("incr_rdata", rq_d[i], 64'h1111_1111_1111_1111 * 64'(i + 1));
      chk("incr_rresp", 64'({rq_r[0], rq_r[1], rq_r[2], rq_r[3]}), 64'h0);
      chk("incr_rlast", 64'(rq_lmask), 64'h8);
      chk("incr_latency", 64'(rq_lat), 64'd2);
      chk("incr_throughput", 64'(rq_span), 64'd3);
      chk("incr_rid", 64'(rq_id), 64'h09);
      chk("r_idle_after", 64'({s_axi_rvalid, s_axi_arready}), 64'h1);

      wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      wr(BASE, 4'd0, INCR, SIZE_8B, 1, 8'hFF, 6'h01, resp, bid);
      wd[0] = 64'h0;
      wr(BASE, 4'd0, INCR, SIZE_8B, 1, 8'h0F, 6'h01, resp, bid);
      chk("strb_bresp", 64'(resp), 64'(OKAY));
      rd(BASE, 4'd0, INCR, SIZE_8B, 6'h01, 0, -1);
      chk("strb_rdata", rq_d[0], 64'hFFFF_FFFF_0000_0000);

      for (int i = 0; i < 16; i++) wd[i] = 64'hC0DE_0000_00BE_EF00 + 64'(i);
      wr(BASE + 32'h100, 4'd15, INCR, SIZE_8B, 16, 8'hFF, 6'h02, resp, bid);
      chk("bp_bresp", 64'(resp), 64'(OKAY));
      rd(BASE + 32'h100, 4'd15, INCR, SIZE_8B, 6'h2A, 1, -1);
      chk("bp_count", 64'(rq_n), 64'd16);
      for (int i = 0; i < 16; i++) chk("bp_rdata", rq_d[i], 64'hC0DE_0000_00BE_EF00 + 64'(i));
      chk("bp_rlast", 64'(rq_lmask), 64'h8000);
      chk("bp_stable", 64'(rq_unstable), 64'h0);
      chk("bp_rid", 64'(rq_id), 64'h2A);

      for (int i = 0; i < 4; i++) wd[i] = 64'h0A0A_0A0A_0A0A_0A00 + 64'(i);
      wr(32'h2000_7FF0, 4'd3, INCR, SIZE_8B, 4, 8'hFF, 6'h03, resp, bid);
      chk("oor_bresp", 64'(resp), 64'(DECERR));
      rd(32'h2000_7FF0, 4'd3, INCR, SIZE_8B, 6'h03, 0, -1);
      chk("oor_rresp", 64'({rq_r[0], rq_r[1], rq_r[2], rq_r[3]}), 64'h0F);
      chk("oor_rdata0", rq_d[0], 64'h0A0A_0A0A_0A0A_0A00);
      chk("oor_rdata1", rq_d[1], 64'h0A0A_0A0A_0A0A_0A01);
      chk("oor_rdata2", rq_d[2], 64'h0);
      chk("oor_rdata3", rq_d[3], 64'h0);

      wd[0] = 64'hDEAD_BEEF_DEAD_BEEF;
      wd[1] = 64'hDEAD_BEEF_DEAD_BEEF;
      wr(BASE, 4'd1, WRAP, SIZE_8B, 2, 8'hFF, 6'h04, resp, bid);
      chk("wrap_bresp", 64'(resp), 64'(SLVERR));
      rd(BASE, 4'd1, INCR, SIZE_8B, 6'h04, 0, -1);
      chk("intact_word0", rq_d[0], 64'hFFFF_FFFF_0000_0000);
      chk("intact_word1", rq_d[1], 64'h2222_2222_2222_2222);

      wr(BASE + 32'h200, 4'd3, INCR, SIZE_8B, 2, 8'hFF, 6'h06, resp, bid);
      chk("early_wlast_bresp", 64'(resp), 64'(SLVERR));
      rd(BASE, 4'd1, WRAP, SIZE_8B, 6'h07, 0, -1);
      chk("wrap_rcount", 64'(rq_n), 64'd2);
      chk("wrap_rresp", 64'({rq_r[0], rq_r[1]}), 64'hA);
      chk("wrap_rdata", rq_d[0] | rq_d[1], 64'h0);
      chk("wrap_rlast", 64'(rq_lmask), 64'h2);
      rd(BASE, 4'd0, INCR, 3'd2, 6'h08, 0, -1);
      chk("size_rresp", 64'(rq_r[0]), 64'(SLVERR));

      wd[0] = 64'h0123_4567_89AB_CDEF;
      wd[1] = 64'hFEDC_BA98_7654_3210;
      wr(BASE + 32'h300, 4'd1, FIXED, SIZE_8B, 2, 8'hFF, 6'h0A, resp, bid);
      chk("fixed_bresp", 64'(resp), 64'(OKAY));
      rd(BASE + 32'h300, 4'd0, INCR, SIZE_8B, 6'h0A, 0, -1);
      chk("fixed_rdata", rq_d[0], 64'hFEDC_BA98_7654_3210);

      rd(BASE + 32'h100, 4'd7, INCR, SIZE_8B, 6'h0B, 0, 1);
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("rel_arready_low", 64'({s_axi_arready, s_axi_rvalid}), 64'h0);
      @(negedge clk_i);
      chk("rel_arready_up", 64'(s_axi_arready), 64'h1);
      rd(BASE + 32'h100, 4'd1, INCR, SIZE_8B, 6'h0C, 0, -1);
      chk("post_rst_data0", rq_d[0], 64'hC0DE_0000_00BE_EF00);
      chk("post_rst_data1", rq_d[1], 64'hC0DE_0000_00BE_EF01);
      rd(BASE, 4'd0, INCR, SIZE_8B, 6'h0C, 0, -1);
      chk("post_rst_word0", rq_d[0], 64'hFFFF_FFFF_0000_0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
- AXI3 responder, 64-bit data, 6-bit IDs; the memory-side counterpart of the frame sink/source masters.
- Backs a BASE-mapped window with on-chip dual-port RAM.
- Substitutes for the PS DDR port in simulation and small-frame builds.
- Read and write channels are independent; each handles one burst at a time.

Parameters:
- BASE, 32'h20000000, byte address of word 0.
- DEPTH, 4096, window size in 64-bit words; window is BASE to BASE+DEPTH*8-1.
- AW, $clog2(DEPTH), RAM word-address width (derived).

Ports:
- clk_i  in  1  clock; all AXI signals are sampled on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- s_axi_aw{valid,ready,addr[31:0],len[3:0],size[2:0],burst[1:0],id[5:0]}  in/out(ready)  write address channel.
- s_axi_w{valid,ready,data[63:0],strb[7:0],last,id[5:0]}  in/out(ready)  write data channel.
- s_axi_b{valid,ready,resp[1:0],id[5:0]}  out/in(ready)  write response channel.
- s_axi_ar{valid,ready,addr[31:0],len[3:0],size[2:0],burst[1:0],id[5:0]}  in/out(ready)  read address channel.
- s_axi_r{valid,ready,data[63:0],resp[1:0],last,id[5:0]}  out/in(ready)  read data channel.
- Lock, cache, prot and qos inputs are accepted and ignored.

Behaviour:
- Reset values: all ready and valid outputs 0; bresp, rresp and rlast 0; ids and rdata 0.
- awready and arready rise on the first edge after rst_i falls.
- A handshake completes on any edge where valid and ready are both 1. Valid outputs never drop before their handshake; payload is held stable while valid=1.
- Word index = (addr-BASE)>>3; addr[2:0] is ignored.
- In range: BASE <= beat_addr < BASE+DEPTH*8, evaluated per beat.
- Address step per beat: INCR adds 8 (size must be 3); FIXED adds 0.
- WRAP, or size != 3, gives SLVERR (2'b10) for the whole burst with no RAM access.
- Write FSM:
  - W_IDLE (awready=1): on AW handshake, latch addr, len, burst and id; go to W_DATA.
  - W_DATA (wready=1): each W handshake writes the byte lanes where strb=1, if the beat is in range; the beat counter increments.
  - W_DATA exits to W_RESP on wlast=1.
  - W_RESP (bvalid=1): on bready, return to W_IDLE.
  - bid = latched awid.
  - bresp priority: SLVERR if wlast position != len, or burst/size illegal; else DECERR (2'b11) if any beat was out of range; else OKAY.
  - Out-of-range beats are dropped. No RAM write occurs in W_IDLE or W_RESP.
- Read FSM:
  - R_IDLE (arready=1): on AR handshake, go to R_BURST.
  - R_BURST: the RAM has 1-cycle latency, so the first beat asserts rvalid at T+2 after an AR handshake at edge T.
  - A 2-entry output skid holds RAM data. A RAM read issues only when the skid has a free slot after the current cycle's pop, so rready backpressure never loses or duplicates data.
  - Sustained throughput is 1 beat/cycle with rready=1.
  - rlast=1 on beat len+1; after the last handshake, return to R_IDLE.
  - rid = latched arid.
  - Per-beat rresp: OKAY; DECERR with rdata=0 if out of range; SLVERR for all beats on illegal burst/size.
- Simultaneous read and write of the same word in one cycle: read returns the old data (read-first).
- Reset mid-burst: both FSMs go to IDLE immediately, the skid is flushed and RAM contents are retained. There is no response for the aborted burst.

Optional Feature:
- Macro: AXI_RAM_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, advances every cycle) gates the readies. awready, wready and arready are masked to 0 when lfsr[1:0]==0. The R-side RAM issue is held off when lfsr[3:2]==0. All valid/payload rules still hold.
- Undefined: no LFSR logic; timing as above.

Decomposition:
- Package axi_pkg holds:
  - resp constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11;
  - burst constants FIXED=2'b00, INCR=2'b01, WRAP=2'b10;
  - SIZE_8B=3'd3.
- Sub-module axi_ram_dp: simple dual-port RAM with one write port (byte enables) and one read port (registered read, read-first), parameters DEPTH and width 64.

Test Plan:
- Write then read, both INCR: AW addr=32'h20000000, len=3, data 64'h1111..., 64'h2222..., 64'h3333..., 64'h4444..., strb=8'hFF. Required: bresp=OKAY, bid=AWID=6'h05. Then AR same addr, len=3. Required: four beats return in order, rlast only on beat 4, first rvalid 2 cycles after the AR handshake.
- Partial strobe: word 0 holds 64'hFFFF_FFFF_FFFF_FFFF; write 64'h0 with strb=8'h0F. Required: readback 64'hFFFF_FFFF_0000_0000.
- R backpressure: AR len=15; rready toggles 1,0,0,1 repeating. Required: 16 beats in order, no drops or duplicates, rdata stable while stalled.
- Out of range: AR addr=BASE+DEPTH*8-16, len=3. Required: beats 1-2 OKAY with data, beats 3-4 DECERR with rdata=0. A write at the same addr/len gives bresp=DECERR and leaves RAM unchanged beyond the window.
- Protocol error: AW len=3, wlast on beat 2. Required: bresp=SLVERR. AR burst=WRAP, len=1: 2 beats returned, both SLVERR.
- Reset mid-burst: assert rst_i during beat 2 of an 8-beat read. Required: rvalid=0 asynchronously, arready=1 one cycle after release, previously written data intact.
